// File: rtl/linebuffer_ctrl_if.sv
// Handshake bundle between the draw-domain scanline controller and its environment.
// master drives the timing/renderer pulses; slave is the controller itself.
interface linebuffer_ctrl_if;
  logic         enable;
  logic         hblank_draw;
  logic         line_start_draw;
  logic         draw_done;
  logic         buffsel_draw;
  logic [6:0]   addr_on_draw;
  logic         we_on_draw;
  logic [127:0] colour_on_draw;
  logic         draw_start;
  logic         draw_busy;
  logic         clear_busy;
  logic         underrun;
  logic [7:0]   underrun_count;

  modport master (
    output enable, hblank_draw, line_start_draw, draw_done,
    input  buffsel_draw, addr_on_draw, we_on_draw, colour_on_draw,
    input  draw_start, draw_busy, clear_busy, underrun, underrun_count
  );

  modport slave (
    input  enable, hblank_draw, line_start_draw, draw_done,
    output buffsel_draw, addr_on_draw, we_on_draw, colour_on_draw,
    output draw_start, draw_busy, clear_busy, underrun, underrun_count
  );
endinterface

// File: rtl/linebuffer_ctrl.sv
// Double-buffered scanline controller: flips buffers, clears the on-screen line
// during hblank, hands the off-screen line to the renderer and tracks underruns.
module linebuffer_ctrl #(
  parameter int unsigned LINE_WORDS   = 80,
  parameter logic [7:0]  CLEAR_COLOUR = 8'h00
) (
  input logic              clk_draw,
  input logic              rst,
  linebuffer_ctrl_if.slave bus
);

  localparam logic [6:0] LastWord = 7'(LINE_WORDS - 1);

  typedef enum logic {C_IDLE, C_RUN} clr_state_e;
  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} drw_state_e;

  clr_state_e clr_q;
  drw_state_e drw_q;
  logic [6:0] addr_q;
  logic       we_q;
  logic       clear_ok_q;
  logic       buffsel_q;
  logic       draw_start_q;
  logic       draw_busy_q;
  logic       underrun_q;
  logic [7:0] count_q;
  logic       first_q;

  logic flip;
  logic clear_last;
  logic underrun_now;

  assign flip       = bus.enable & bus.line_start_draw;
  assign clear_last = (clr_q == C_RUN) & (addr_q == LastWord);

  // A clear finishing or a draw_done arriving on the flip edge still counts.
  assign underrun_now = ~first_q &
                        (((drw_q == D_BUSY) & ~bus.draw_done) | ~(clear_ok_q | clear_last));

  always_ff @(posedge clk_draw or posedge rst) begin
    if (rst) begin
      clr_q      <= C_IDLE;
      addr_q     <= 7'd0;
      we_q       <= 1'b0;
      clear_ok_q <= 1'b0;
    end else begin
      if (flip) begin
        clear_ok_q <= 1'b0;
      end else if (clear_last) begin
        clear_ok_q <= 1'b1;
      end
      unique case (clr_q)
        C_IDLE: begin
          if (bus.hblank_draw && bus.enable && !flip) begin
            clr_q  <= C_RUN;
            addr_q <= 7'd0;
            we_q   <= 1'b1;
          end
        end
        C_RUN: begin
          // A flip aborts on the same edge so no write lands in the new buffer.
          if (flip || clear_last) begin
            clr_q  <= C_IDLE;
            addr_q <= 7'd0;
            we_q   <= 1'b0;
          end else begin
            addr_q <= addr_q + 7'd1;
          end
        end
        default: begin
          clr_q <= C_IDLE;
          we_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_draw or posedge rst) begin
    if (rst) begin
      drw_q        <= D_IDLE;
      buffsel_q    <= 1'b0;
      draw_start_q <= 1'b0;
      draw_busy_q  <= 1'b0;
      underrun_q   <= 1'b0;
      count_q      <= 8'd0;
      first_q      <= 1'b1;
    end else begin
      if (flip) begin
        buffsel_q    <= ~buffsel_q;
        drw_q        <= D_BUSY;
        draw_busy_q  <= 1'b1;
        draw_start_q <= 1'b1;
        underrun_q   <= underrun_now;
        first_q      <= 1'b0;
        if (underrun_now && (count_q != 8'hff)) begin
          count_q <= count_q + 8'd1;
        end
      end else begin
        draw_start_q <= 1'b0;
        underrun_q   <= 1'b0;
        if ((drw_q == D_BUSY) && bus.draw_done) begin
          drw_q       <= D_DONE;
          draw_busy_q <= 1'b0;
        end
      end
    end
  end

  assign bus.buffsel_draw   = buffsel_q;
  assign bus.addr_on_draw   = addr_q;
  assign bus.we_on_draw     = we_q;
  assign bus.colour_on_draw = {16{CLEAR_COLOUR}};
  assign bus.draw_start     = draw_start_q;
  assign bus.draw_busy      = draw_busy_q;
  assign bus.clear_busy     = (clr_q == C_RUN);
  assign bus.underrun       = underrun_q;
  assign bus.underrun_count = count_q;

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Bench for linebuffer_ctrl: directed line scenarios with literal expectations,
// then random pulse traffic, all compared each cycle against a behavioural model.
module tb_linebuffer_ctrl;
  localparam int unsigned LW = 80;
  localparam logic [7:0]  CC = 8'hA5;

  logic clk_draw = 1'b0;
  logic rst      = 1'b1;

  linebuffer_ctrl_if bus ();

  linebuffer_ctrl #(
    .LINE_WORDS  (LW),
    .CLEAR_COLOUR(CC)
  ) dut (
    .clk_draw(clk_draw),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_draw = ~clk_draw;

  int n_vec = 0;
  int n_bad = 0;

  // Model: which buffer is shown, where the clear is, what the renderer owes.
  bit m_sel, m_clr, m_ok, m_busy, m_first, m_start, m_under;
  int m_word, m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_clr = 0; m_ok = 0; m_busy = 0; m_first = 1;
    m_start = 0; m_under = 0; m_word = 0; m_cnt = 0;
  endtask

  task automatic model_update();
    bit flip, fin;
    flip = bus.enable && bus.line_start_draw;
    fin  = m_clr && (m_word == int'(LW) - 1);
    if (flip) begin
      m_under = !m_first && ((m_busy && !bus.draw_done) || !(m_ok || fin));
      if (m_under && m_cnt < 255) m_cnt++;
      m_first = 0;
      m_sel   = !m_sel;
      m_start = 1;
      m_busy  = 1;
      m_clr   = 0;
      m_word  = 0;
      m_ok    = 0;
    end else begin
      m_under = 0;
      m_start = 0;
      if (m_busy && bus.draw_done) m_busy = 0;
      if (fin) m_ok = 1;
      if (m_clr) begin
        if (fin) begin
          m_clr  = 0;
          m_word = 0;
        end else begin
          m_word++;
        end
      end else if (bus.hblank_draw && bus.enable) begin
        m_clr  = 1;
        m_word = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("buffsel", 64'(bus.buffsel_draw), 64'(m_sel));
    chk("addr", 64'(bus.addr_on_draw), m_clr ? 64'(m_word) : 64'd0);
    chk("we", 64'(bus.we_on_draw), 64'(m_clr));
    chk("clear_busy", 64'(bus.clear_busy), 64'(m_clr));
    chk("draw_start", 64'(bus.draw_start), 64'(m_start));
    chk("draw_busy", 64'(bus.draw_busy), 64'(m_busy));
    chk("underrun", 64'(bus.underrun), 64'(m_under));
    chk("underrun_count", 64'(bus.underrun_count), 64'(m_cnt));
    chk("colour", 64'(bus.colour_on_draw === {16{CC}}), 64'd1);
  endtask

  // Called at a negedge: drive one cycle of inputs, let the edge happen,
  // advance the model, then compare at the following negedge.
  task automatic step(input bit en, input bit hb, input bit ls, input bit dd);
    bus.enable          = en;
    bus.hblank_draw     = hb;
    bus.line_start_draw = ls;
    bus.draw_done       = dd;
    @(posedge clk_draw);
    if (rst) model_reset();
    else model_update();
    @(negedge clk_draw);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    int we_cnt, busy_cnt;
    bit sel_keep;
    bus.enable = 0; bus.hblank_draw = 0; bus.line_start_draw = 0; bus.draw_done = 0;
    model_reset();
    repeat (2) @(negedge clk_draw);
    compare_all();
    chk("rst_buffsel", 64'(bus.buffsel_draw), 64'd0);
    chk("rst_we", 64'(bus.we_on_draw), 64'd0);
    chk("rst_count", 64'(bus.underrun_count), 64'd0);
    rst = 0;
    idle(2);

    // Full clear: 80 writes at addresses 0..79.
    step(1, 1, 0, 0);
    we_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 85; i++) begin
      if (bus.we_on_draw === 1'b1) we_cnt++;
      if (bus.clear_busy === 1'b1) busy_cnt++;
      if (i < 80) chk("clear_addr", 64'(bus.addr_on_draw), 64'(i));
      step(1, 0, 0, 0);
    end
    chk("clear_we_cycles", 64'(we_cnt), 64'd80);
    chk("clear_busy_cycles", 64'(busy_cnt), 64'd80);

    // Normal line: first flip, renderer finishes, clear completes, flip again.
    step(1, 0, 1, 0);
    chk("flip1_start", 64'(bus.draw_start), 64'd1);
    chk("flip1_sel", 64'(bus.buffsel_draw), 64'd1);
    chk("flip1_under", 64'(bus.underrun), 64'd0);
    step(1, 0, 0, 1);
    chk("start_one_cycle", 64'(bus.draw_start), 64'd0);
    step(1, 1, 0, 0);
    idle(80);
    step(1, 0, 1, 0);
    chk("flip2_sel", 64'(bus.buffsel_draw), 64'd0);
    chk("flip2_start", 64'(bus.draw_start), 64'd1);
    chk("flip2_under", 64'(bus.underrun), 64'd0);

    // Flip at clear word 40 aborts the clear and underruns.
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    idle(40);
    chk("word40_addr", 64'(bus.addr_on_draw), 64'd40);
    chk("word40_we", 64'(bus.we_on_draw), 64'd1);
    step(1, 0, 1, 0);
    chk("abort_we", 64'(bus.we_on_draw), 64'd0);
    chk("abort_under", 64'(bus.underrun), 64'd1);
    chk("abort_count", 64'(bus.underrun_count), 64'd1);
    step(1, 0, 0, 0);
    chk("under_one_cycle", 64'(bus.underrun), 64'd0);

    // Clear done, but renderer never finished.
    step(1, 1, 0, 0);
    idle(80);
    step(1, 0, 1, 0);
    chk("nodone_under", 64'(bus.underrun), 64'd1);
    chk("nodone_count", 64'(bus.underrun_count), 64'd2);
    // draw_done on the flip edge counts as finished.
    step(1, 1, 0, 0);
    idle(80);
    step(1, 0, 1, 1);
    chk("done_on_flip_under", 64'(bus.underrun), 64'd0);
    chk("done_on_flip_count", 64'(bus.underrun_count), 64'd2);

    // Saturation after 300 underrun lines.
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 1, 0);
      step(1, 0, 0, 0);
    end
    chk("sat_count", 64'(bus.underrun_count), 64'd255);

    // enable=0 ignores flips and hblank.
    sel_keep = bus.buffsel_draw;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      chk("dis_start", 64'(bus.draw_start), 64'd0);
      chk("dis_sel", 64'(bus.buffsel_draw), 64'(sel_keep));
    end
    step(0, 1, 0, 0);
    chk("dis_hblank", 64'(bus.clear_busy), 64'd0);

    // enable=0 mid-clear keeps clearing.
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("dis_clear_addr", 64'(bus.addr_on_draw), 64'd2);

    // Reset mid-clear drops the write enable without a clock edge.
    #2 rst = 1;
    #1;
    chk("async_rst_we", 64'(bus.we_on_draw), 64'd0);
    chk("async_rst_addr", 64'(bus.addr_on_draw), 64'd0);
    model_reset();
    @(negedge clk_draw);
    compare_all();
    rst = 0;
    idle(3);

    // Random traffic.
    for (int i = 0; i < 20000; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 119) == 0), ($urandom_range(0, 19) == 0));
    end
    // Regular lines with jittered renderer completion.
    for (int l = 0; l < 60; l++) begin
      int dd_at;
      dd_at = $urandom_range(1, 110);
      step(1, 0, 1, 0);
      for (int c = 0; c < 100; c++) begin
        step(1, (c == 3), 0, (c == dd_at));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
